// File: rtl/matrix_axil_pkg.sv
`default_nettype none
// ============================================================================
// Module   : matrix_axil_pkg
// Purpose  : Shared constants, FSM state types and byte-merge helper for the
//            LED matrix AXI4-Lite register slave.
// Revision : 1.0
// ============================================================================
package matrix_axil_pkg;

    localparam logic [1:0] REG_CTRL0     = 2'd0;
    localparam logic [1:0] REG_CTRL1     = 2'd1;
    localparam logic [1:0] REG_CTRL2     = 2'd2;
    localparam logic [1:0] REG_CTRL3     = 2'd3;
    localparam logic [1:0] AXI_RESP_OKAY = 2'b00;

    typedef enum logic [1:0] {
        WR_IDLE   = 2'd0,
        WR_COMMIT = 2'd1,
        WR_RESP   = 2'd2
    } wr_state_t;

    typedef enum logic {
        RD_IDLE = 1'b0,
        RD_DATA = 1'b1
    } rd_state_t;

    // Lanes with a strobe bit take the new byte; the rest keep the old value.
    function automatic logic [31:0] merge_bytes(
        input logic [31:0] i_old,
        input logic [31:0] i_new,
        input logic [3:0]  i_strb
    );
        logic [31:0] w_res;
        w_res = i_old;
        for (int b = 0; b < 4; b++) begin
            if (i_strb[b]) begin
                w_res[8*b +: 8] = i_new[8*b +: 8];
            end
        end
        return w_res;
    endfunction

endpackage
`default_nettype wire

// File: rtl/matrix_axil_wr_hold.sv
`default_nettype none
// ============================================================================
// Module   : matrix_axil_wr_hold
// Purpose  : Single-entry holding register with valid flag for one AXI
//            write-side channel (AW or W).
// Revision : 1.0
// ============================================================================
module matrix_axil_wr_hold #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_load,
    input  logic             i_clear,
    input  logic [WIDTH-1:0] i_data,
    output logic             o_valid,
    output logic [WIDTH-1:0] o_data
);

    logic             r_valid;
    logic [WIDTH-1:0] r_data;

    // Clear wins: the owner never loads and clears in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_data  <= '0;
        end else if (i_clear) begin
            r_valid <= 1'b0;
        end else if (i_load) begin
            r_valid <= 1'b1;
            r_data  <= i_data;
        end
    end

    assign o_valid = r_valid;
    assign o_data  = r_data;

endmodule
`default_nettype wire

// File: rtl/matrix_axil_slave.sv
`default_nettype none
// ============================================================================
// Module   : matrix_axil_slave
// Purpose  : AXI4-Lite slave exposing four 32-bit control registers and
//            per-register write pulses to the LED matrix scan logic.
// Revision : 1.0
// ============================================================================
module matrix_axil_slave
    import matrix_axil_pkg::*;
#(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 4,
    parameter int NUM_REGS           = 4
) (
    input  logic                                   s00_axi_aclk,
    input  logic                                   s00_axi_aresetn,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]          s00_axi_awaddr,
    input  logic [2:0]                             s00_axi_awprot,
    input  logic                                   s00_axi_awvalid,
    output logic                                   s00_axi_awready,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]          s00_axi_wdata,
    input  logic [3:0]                             s00_axi_wstrb,
    input  logic                                   s00_axi_wvalid,
    output logic                                   s00_axi_wready,
    output logic [1:0]                             s00_axi_bresp,
    output logic                                   s00_axi_bvalid,
    input  logic                                   s00_axi_bready,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]          s00_axi_araddr,
    input  logic [2:0]                             s00_axi_arprot,
    input  logic                                   s00_axi_arvalid,
    output logic                                   s00_axi_arready,
    output logic [C_S_AXI_DATA_WIDTH-1:0]          s00_axi_rdata,
    output logic [1:0]                             s00_axi_rresp,
    output logic                                   s00_axi_rvalid,
    input  logic                                   s00_axi_rready,
    output logic [NUM_REGS*C_S_AXI_DATA_WIDTH-1:0] ctrl_regs,
    output logic [NUM_REGS-1:0]                    reg_wr_pulse
);

    logic                                          r_active;
    wr_state_t                                     r_wr_state;
    rd_state_t                                     r_rd_state;
    logic [NUM_REGS-1:0][C_S_AXI_DATA_WIDTH-1:0]   r_regs;
    logic [NUM_REGS-1:0]                           r_pulse;
    logic                                          r_bvalid;
    logic                                          r_rvalid;
    logic [C_S_AXI_DATA_WIDTH-1:0]                 r_rdata;

    logic                                          w_awready;
    logic                                          w_wready;
    logic                                          w_arready;
    logic                                          w_aw_hs;
    logic                                          w_w_hs;
    logic                                          w_ar_hs;
    logic                                          w_b_hs;
    logic                                          w_aw_held;
    logic                                          w_w_held;
    logic [1:0]                                    w_aw_idx;
    logic [C_S_AXI_DATA_WIDTH-1:0]                 w_w_data;
    logic [3:0]                                    w_w_strb;
    logic [1:0]                                    w_ar_idx;
    logic [NUM_REGS-1:0]                           w_sel;
    logic                                          w_unused;

    // Readies stay low through reset and for the first cycle after release.
    always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
        if (!s00_axi_aresetn) begin
            r_active <= 1'b0;
        end else begin
            r_active <= 1'b1;
        end
    end

    assign w_awready = r_active && (r_wr_state == WR_IDLE) && !w_aw_held;
    assign w_wready  = r_active && (r_wr_state == WR_IDLE) && !w_w_held;
    assign w_arready = r_active && (r_rd_state == RD_IDLE);
    assign w_aw_hs   = s00_axi_awvalid && w_awready;
    assign w_w_hs    = s00_axi_wvalid  && w_wready;
    assign w_ar_hs   = s00_axi_arvalid && w_arready;
    assign w_b_hs    = (r_wr_state == WR_RESP) && s00_axi_bready;
    assign w_ar_idx  = s00_axi_araddr[3:2];

    matrix_axil_wr_hold #(
        .WIDTH (2)
    ) u_aw_hold (
        .clk     (s00_axi_aclk),
        .rst_n   (s00_axi_aresetn),
        .i_load  (w_aw_hs),
        .i_clear (w_b_hs),
        .i_data  (s00_axi_awaddr[3:2]),
        .o_valid (w_aw_held),
        .o_data  (w_aw_idx)
    );

    matrix_axil_wr_hold #(
        .WIDTH (C_S_AXI_DATA_WIDTH + 4)
    ) u_w_hold (
        .clk     (s00_axi_aclk),
        .rst_n   (s00_axi_aresetn),
        .i_load  (w_w_hs),
        .i_clear (w_b_hs),
        .i_data  ({s00_axi_wstrb, s00_axi_wdata}),
        .o_valid (w_w_held),
        .o_data  ({w_w_strb, w_w_data})
    );

    always_comb begin
        w_sel = '0;
        case (w_aw_idx)
            REG_CTRL0: w_sel = 4'b0001;
            REG_CTRL1: w_sel = 4'b0010;
            REG_CTRL2: w_sel = 4'b0100;
            REG_CTRL3: w_sel = 4'b1000;
            default:   w_sel = '0;
        endcase
    end

    always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
        if (!s00_axi_aresetn) begin
            r_wr_state <= WR_IDLE;
            r_regs     <= '0;
            r_pulse    <= '0;
            r_bvalid   <= 1'b0;
        end else begin
            r_pulse <= '0;
            case (r_wr_state)
                WR_IDLE: begin
                    if ((w_aw_held || w_aw_hs) && (w_w_held || w_w_hs)) begin
                        r_wr_state <= WR_COMMIT;
                    end
                end
                WR_COMMIT: begin
                    r_regs[w_aw_idx] <= merge_bytes(r_regs[w_aw_idx], w_w_data, w_w_strb);
                    r_pulse          <= w_sel;
                    r_bvalid         <= 1'b1;
                    r_wr_state       <= WR_RESP;
                end
                WR_RESP: begin
                    if (s00_axi_bready) begin
                        r_bvalid   <= 1'b0;
                        r_wr_state <= WR_IDLE;
                    end
                end
                default: begin
                    r_bvalid   <= 1'b0;
                    r_wr_state <= WR_IDLE;
                end
            endcase
        end
    end

    // Captures the register before any same-edge commit lands.
    always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
        if (!s00_axi_aresetn) begin
            r_rd_state <= RD_IDLE;
            r_rvalid   <= 1'b0;
            r_rdata    <= '0;
        end else begin
            case (r_rd_state)
                RD_IDLE: begin
                    if (w_ar_hs) begin
                        r_rdata    <= r_regs[w_ar_idx];
                        r_rvalid   <= 1'b1;
                        r_rd_state <= RD_DATA;
                    end
                end
                RD_DATA: begin
                    if (s00_axi_rready) begin
                        r_rvalid   <= 1'b0;
                        r_rd_state <= RD_IDLE;
                    end
                end
                default: begin
                    r_rvalid   <= 1'b0;
                    r_rd_state <= RD_IDLE;
                end
            endcase
        end
    end

    assign s00_axi_awready = w_awready;
    assign s00_axi_wready  = w_wready;
    assign s00_axi_arready = w_arready;
    assign s00_axi_bresp   = AXI_RESP_OKAY;
    assign s00_axi_bvalid  = r_bvalid;
    assign s00_axi_rresp   = AXI_RESP_OKAY;
    assign s00_axi_rvalid  = r_rvalid;
    assign s00_axi_rdata   = r_rdata;
    assign ctrl_regs       = r_regs;
    assign reg_wr_pulse    = r_pulse;

    assign w_unused = ^{s00_axi_awprot, s00_axi_arprot, s00_axi_awaddr, s00_axi_araddr};

endmodule
`default_nettype wire
